// File: rtl/movement_pkg.sv
// Shared motor codes and state encoding for the movement sequencer.
package movement_pkg;

    localparam logic [1:0] MOTOR_OFF = 2'b00;
    localparam logic [1:0] MOTOR_FWD = 2'b01;
    localparam logic [1:0] MOTOR_REV = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FORWARD = 3'd1,
        ST_BRAKE   = 3'd2,
        ST_REVERSE = 3'd3,
        ST_TURN    = 3'd4
    } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level, plus a rising-edge pulse
// taken from one extra history flop behind the synchronised level.
module sync_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~hist_q;

endmodule

// File: rtl/movement_sequencer.sv
// Obstacle-avoidance sequencer: forward / brake / reverse / turn phases timed
// in synchronised slow ticks, with a saturating count of obstacle hits.
module movement_sequencer
    import movement_pkg::*;
#(
    parameter int unsigned BRAKE_TICKS = 2,
    parameter int unsigned REV_TICKS   = 4,
    parameter int unsigned TURN_TICKS  = 3,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       slow_tick,
    input  logic       obstacle,
    input  logic       start,
    input  logic       stop,
    output logic [1:0] motor_left,
    output logic [1:0] motor_right,
    output logic [2:0] state,
    output logic       busy,
    output logic [7:0] obstacle_count
);

    localparam logic [CNT_W-1:0] BRAKE_LAST = CNT_W'(BRAKE_TICKS - 1);
    localparam logic [CNT_W-1:0] REV_LAST   = CNT_W'(REV_TICKS - 1);
    localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_TICKS - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick_pulse;
    logic              tick_level_unused;
    logic              obs_level;
    logic              obs_rise_unused;
    logic              count_inc;

    sync_edge_detect u_tick_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (slow_tick),
        .level    (tick_level_unused),
        .rise     (tick_pulse)
    );

    sync_edge_detect u_obs_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (obstacle),
        .level    (obs_level),
        .rise     (obs_rise_unused)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_FORWARD;
            ST_FORWARD: if (obs_level) state_d = ST_BRAKE;
            ST_BRAKE:   if (tick_pulse && cnt_q == BRAKE_LAST) state_d = ST_REVERSE;
            ST_REVERSE: if (tick_pulse && cnt_q == REV_LAST) state_d = ST_TURN;
            ST_TURN:    if (tick_pulse && cnt_q == TURN_LAST) state_d = ST_FORWARD;
            default:    state_d = ST_IDLE;
        endcase
        if (stop) state_d = ST_IDLE;

        // Counter restarts on any state change so each phase sees a fresh count.
        cnt_d = cnt_q;
        if (stop || state_d != state_q) cnt_d = '0;
        else if (tick_pulse)            cnt_d = cnt_q + 1'b1;

        count_inc = (state_q == ST_FORWARD) && (state_d == ST_BRAKE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            obstacle_count <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (count_inc && obstacle_count != '1) obstacle_count <= obstacle_count + 8'd1;
        end
    end

    always_comb begin
        motor_left  = MOTOR_OFF;
        motor_right = MOTOR_OFF;
        case (state_q)
            ST_FORWARD: begin motor_left = MOTOR_FWD; motor_right = MOTOR_FWD; end
            ST_REVERSE: begin motor_left = MOTOR_REV; motor_right = MOTOR_REV; end
            ST_TURN:    begin motor_left = MOTOR_FWD; motor_right = MOTOR_REV; end
            default:    ;
        endcase
    end

    assign state = state_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_movement_sequencer.sv
// Randomised bench for movement_sequencer against a phase/ticks-remaining
// reference model fed by the raw inputs sampled at every clock edge.
module tb_movement_sequencer;

    localparam int BRAKE_T = 2;
    localparam int REV_T   = 4;
    localparam int TURN_T  = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       slow_tick = 1'b0;
    logic       obstacle = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] motor_left, motor_right;
    logic [2:0] state;
    logic       busy;
    logic [7:0] obstacle_count;

    int errors = 0;
    int checks = 0;
    int tick_lo = 2;
    int tick_hi = 4;

    movement_sequencer #(
        .BRAKE_TICKS (BRAKE_T),
        .REV_TICKS   (REV_T),
        .TURN_TICKS  (TURN_T),
        .CNT_W       (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .slow_tick      (slow_tick),
        .obstacle       (obstacle),
        .start          (start),
        .stop           (stop),
        .motor_left     (motor_left),
        .motor_right    (motor_right),
        .state          (state),
        .busy           (busy),
        .obstacle_count (obstacle_count)
    );

    initial forever #5 clock = ~clock;

    // Free-running slow clock; each half lasts a random number of system clocks.
    initial forever begin
        int h;
        h = $urandom_range(tick_hi, tick_lo);
        repeat (h) @(negedge clock);
        slow_tick = ~slow_tick;
    end

    // Reference model: phase number, ticks remaining in the phase, hit count.
    int m_phase = 0;
    int m_left  = 0;
    int m_cnt   = 0;
    logic [1:0] o_d = '0;
    logic [2:0] t_d = '0;

    always @(posedge clock or negedge reset) begin : model
        int np, nl, nc;
        bit obs, tk;
        if (!reset) begin
            m_phase <= 0; m_left <= 0; m_cnt <= 0;
            o_d <= '0; t_d <= '0;
        end else begin
            obs = o_d[1];
            tk  = t_d[1] && !t_d[2];
            np = m_phase; nl = m_left; nc = m_cnt;
            if (stop) np = 0;
            else case (m_phase)
                0: if (start) np = 1;
                1: if (obs) begin np = 2; nl = BRAKE_T; nc = (m_cnt < 255) ? m_cnt + 1 : 255; end
                2: if (tk) begin if (m_left == 1) begin np = 3; nl = REV_T; end else nl = m_left - 1; end
                3: if (tk) begin if (m_left == 1) begin np = 4; nl = TURN_T; end else nl = m_left - 1; end
                4: if (tk) begin if (m_left == 1) np = 1; else nl = m_left - 1; end
                default: np = 0;
            endcase
            m_phase <= np; m_left <= nl; m_cnt <= nc;
            o_d <= {o_d[0], obstacle};
            t_d <= {t_d[1:0], slow_tick};
        end
    end

    function automatic logic [15:0] exp_bundle();
        logic [3:0] lr;
        case (m_phase)
            1:       lr = 4'b0101;
            3:       lr = 4'b1010;
            4:       lr = 4'b0110;
            default: lr = 4'b0000;
        endcase
        return {3'(m_phase), lr, (m_phase != 0), 8'(m_cnt)};
    endfunction

    logic [15:0] dut_bundle;
    assign dut_bundle = {state, motor_left, motor_right, busy, obstacle_count};

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (dut_bundle !== 16'h0000) begin
            errors++; $display("FAIL reset_state: got %h expected %h", dut_bundle, 16'h0000);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (dut_bundle !== exp_bundle()) begin
            errors++; $display("FAIL reset_release: got %h expected %h", dut_bundle, exp_bundle());
        end
    endtask

    task automatic test_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if ({state, motor_left, motor_right, busy, obstacle_count} !== {3'd1, 4'b0101, 1'b1, 8'd0}) begin
            errors++; $display("FAIL start_forward: got %h expected %h", dut_bundle, {3'd1, 4'b0101, 1'b1, 8'd0});
        end
        checks++;
        if (dut_bundle !== exp_bundle()) begin
            errors++; $display("FAIL start_model: got %h expected %h", dut_bundle, exp_bundle());
        end
    endtask

    task automatic test_obstacle_cycle();
        bit done;
        repeat (3) @(negedge clock);
        obstacle = 1'b1;
        @(negedge clock);
        obstacle = 1'b0;
        @(negedge clock);
        checks++;
        if (state !== 3'd1) begin
            errors++; $display("FAIL obs_latency_k1: got %0d expected %0d", state, 1);
        end
        @(negedge clock);
        checks++;
        if ({state, motor_left, motor_right} !== {3'd2, 4'b0000}) begin
            errors++; $display("FAIL obs_latency_k2: got %h expected %h", {state, motor_left, motor_right}, {3'd2, 4'b0000});
        end
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clock);
            checks++;
            if (dut_bundle !== exp_bundle()) begin
                errors++; $display("FAIL obs_cycle: got %h expected %h", dut_bundle, exp_bundle());
            end
            if (state == 3'd1) done = 1'b1;
        end
        checks++;
        if (!done || {motor_left, motor_right, obstacle_count} !== {4'b0101, 8'd1}) begin
            errors++; $display("FAIL obs_cycle_end: got %h expected %h done=%0d", {motor_left, motor_right, obstacle_count}, {4'b0101, 8'd1}, done);
        end
    endtask

    task automatic test_saturation();
        int loops;
        logic [2:0] prev;
        tick_lo = 2; tick_hi = 2;
        obstacle = 1'b1;
        loops = 0;
        prev = state;
        for (int i = 0; i < 20000 && loops < 300; i++) begin
            @(negedge clock);
            checks++;
            if (dut_bundle !== exp_bundle()) begin
                errors++; $display("FAIL saturation_step: got %h expected %h", dut_bundle, exp_bundle());
            end
            if (prev == 3'd1 && state == 3'd2) loops++;
            prev = state;
        end
        obstacle = 1'b0;
        checks++;
        if (loops != 300 || obstacle_count !== 8'd255) begin
            errors++; $display("FAIL saturation_count: got %0d expected %0d loops=%0d", obstacle_count, 255, loops);
        end
        tick_lo = 2; tick_hi = 4;
    endtask

    task automatic test_stop_mid_reverse();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clock);
            checks++;
            if (dut_bundle !== exp_bundle()) begin
                errors++; $display("FAIL stop_wait: got %h expected %h", dut_bundle, exp_bundle());
            end
            if (m_phase == 3 && m_left == REV_T - 2) done = 1'b1;
        end
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        checks++;
        if (!done || {state, motor_left, motor_right, busy} !== {3'd0, 4'b0000, 1'b0}) begin
            errors++; $display("FAIL stop_idle: got %h expected %h done=%0d", {state, motor_left, motor_right, busy}, {3'd0, 4'b0000, 1'b0}, done);
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (state !== 3'd1) begin
            errors++; $display("FAIL stop_restart: got %0d expected %0d", state, 1);
        end
        obstacle = 1'b1;
        @(negedge clock);
        obstacle = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            checks++;
            if (dut_bundle !== exp_bundle()) begin
                errors++; $display("FAIL restart_phase: got %h expected %h", dut_bundle, exp_bundle());
            end
        end
    endtask

    task automatic test_start_stop_same();
        stop = 1'b1;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0; stop = 1'b0;
        checks++;
        if ({state, busy} !== {3'd0, 1'b0}) begin
            errors++; $display("FAIL start_stop_same: got %h expected %h", {state, busy}, {3'd0, 1'b0});
        end
    endtask

    task automatic test_obstacle_in_turn();
        bit done;
        int c0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        obstacle = 1'b1;
        @(negedge clock);
        obstacle = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clock);
            if (state == 3'd4) done = 1'b1;
        end
        c0 = m_cnt;
        obstacle = 1'b1; start = 1'b1;
        repeat (2) @(negedge clock);
        obstacle = 1'b0; start = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clock);
            checks++;
            if (dut_bundle !== exp_bundle()) begin
                errors++; $display("FAIL turn_obstacle: got %h expected %h", dut_bundle, exp_bundle());
            end
            if (state == 3'd1) done = 1'b1;
        end
        checks++;
        if (!done || obstacle_count !== 8'(c0)) begin
            errors++; $display("FAIL turn_no_count: got %0d expected %0d done=%0d", obstacle_count, c0, done);
        end
    endtask

    task automatic test_async_reset();
        bit done;
        obstacle = 1'b1;
        @(negedge clock);
        obstacle = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clock);
            if (state == 3'd4) done = 1'b1;
        end
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (!done || dut_bundle !== 16'h0000) begin
            errors++; $display("FAIL async_reset: got %h expected %h done=%0d", dut_bundle, 16'h0000, done);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({state, obstacle_count} !== {3'd0, 8'd0} || dut_bundle !== exp_bundle()) begin
            errors++; $display("FAIL reset_resume: got %h expected %h", dut_bundle, exp_bundle());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 19) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 14) == 0) obstacle = ~obstacle;
            @(negedge clock);
            checks++;
            if (dut_bundle !== exp_bundle()) begin
                errors++; $display("FAIL random_step%0d: got %h expected %h", i, dut_bundle, exp_bundle());
            end
        end
        start = 1'b0; stop = 1'b0; obstacle = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_obstacle_cycle();
        test_saturation();
        test_stop_mid_reverse();
        test_start_stop_same();
        test_obstacle_in_turn();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
